// File: rtl/mask_loader_pkg.sv
// Shared types and constants for the convolution mask loader.
// Holds Avalon geometry, the mask vector type, FSM states and beat unpack.
package mask_loader_pkg;

    localparam int NUM_COEF  = 9;
    localparam int WORD_W    = 32;
    localparam int AVL_DW    = 128;
    localparam int AVL_AW    = 26;
    localparam int LANES     = AVL_DW / WORD_W;
    localparam int NUM_BEATS = (NUM_COEF * WORD_W + AVL_DW - 1) / AVL_DW;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_BEAT = cnt_t'(NUM_BEATS - 1);
    localparam cnt_t ALL_BEATS = cnt_t'(NUM_BEATS);

    // mask[i] is coefficient i
    typedef logic [NUM_COEF-1:0][WORD_W-1:0] mask_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        ISSUE,
        WAIT_DATA,
        DONE,
        DRAIN
    } state_t;

    // Scatter one read beat into the mask: lane j of beat b lands on
    // coefficient LANES*b+j; lanes past the last coefficient are dropped.
    function automatic mask_t unpack_beat(
        mask_t              cur,
        cnt_t               beat,
        logic [AVL_DW-1:0]  data
    );
        mask_t m;
        m = cur;
        for (int i = 0; i < NUM_COEF; i++) begin
            if (i / LANES == int'(beat))
                m[i] = data[WORD_W*(i%LANES) +: WORD_W];
        end
        return m;
    endfunction

endpackage

// File: rtl/mask_loader.sv
// Fetches the 3x3 coefficient mask from DDR3 over Avalon and holds it
// for the ALU. Ports: clk/reset_n/reset, load_ddr+start_address in,
// ready+mask out, Avalon read master (avl_*) and local_init_done.
module mask_loader
    import mask_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset,
    input  logic              load_ddr,
    input  logic [AVL_AW-1:0] start_address,
    output logic              ready,
    output mask_t             mask,
    input  logic              local_init_done,
    input  logic              avl_wait_request_n,
    input  logic              avl_readdatavalid,
    input  logic [AVL_DW-1:0] avl_readdata,
    output logic [AVL_AW-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_burstbegin,
    output logic              avl_write,
    output logic [AVL_DW-1:0] avl_writedata
);

    state_t            state;
    state_t            state_nx;
    logic [AVL_AW-1:0] base;
    cnt_t              issue_cnt;
    cnt_t              recv_cnt;
    cnt_t              issue_nx;
    cnt_t              recv_nx;
    logic              accept;
    logic              counting;
    logic              start;
    logic              capture;

    assign accept = (state == ISSUE) && avl_wait_request_n;

    // Beats are only accounted for while a read can be in flight;
    // strays in IDLE/DONE/WAIT_INIT are ignored.
    assign counting = (state == ISSUE) || (state == WAIT_DATA)
                   || (state == DRAIN);

    // Counts including this cycle's acceptance and return, so a soft
    // reset sees exactly how many beats are still owed by the controller.
    assign issue_nx = issue_cnt + cnt_t'(accept);
    assign recv_nx  = recv_cnt + cnt_t'(avl_readdatavalid && counting);

    assign start = !reset && load_ddr
                && ((state == IDLE) || (state == DONE));

    assign capture = !reset && avl_readdatavalid
                  && ((state == ISSUE) || (state == WAIT_DATA));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (reset) begin
            state_nx = (issue_nx != recv_nx) ? DRAIN : IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (load_ddr)
                        state_nx = WAIT_INIT;
                end
                WAIT_INIT: begin
                    if (local_init_done)
                        state_nx = ISSUE;
                end
                ISSUE: begin
                    if (accept && issue_cnt == LAST_BEAT)
                        state_nx = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (recv_nx == ALL_BEATS)
                        state_nx = DONE;
                end
                DRAIN: begin
                    if (recv_nx == issue_cnt)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            ready     <= 1'b0;
            mask      <= '0;
        end else begin
            issue_cnt <= issue_nx;
            recv_cnt  <= recv_nx;
            ready     <= (state_nx == DONE);
            if (start) begin
                base      <= start_address;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (capture)
                mask <= unpack_beat(mask, recv_cnt, avl_readdata);
            if (reset)
                mask <= '0;
        end
    end

    // Command is a pure function of state so it stays stable under stall.
    always_comb begin
        avl_read       = (state == ISSUE);
        avl_burstbegin = (state == ISSUE);
        avl_address    = base + AVL_AW'(issue_cnt);
    end

    assign avl_write     = 1'b0;
    assign avl_writedata = '0;

endmodule
